// File: rtl/sdram_arbiter.sv
// N-channel request arbiter in front of a single-port SDRAM controller.
// Latches request strobes, grants one access at a time and passes HPS download through.
module sdram_arbiter #(
  parameter int NUM_CH = 4,
  parameter int AW     = 25,
  parameter bit RR_EN  = 1'b0
) (
  input  logic                 clk_sys,
  input  logic                 RESET,
  input  logic [NUM_CH-1:0]    ch_req,
  input  logic [NUM_CH-1:0]    ch_en,
  input  logic [NUM_CH-1:0]    ch_we,
  input  logic [NUM_CH-1:0]    ch_burst,
  input  logic [NUM_CH*AW-1:0] ch_addr,
  input  logic [NUM_CH*16-1:0] ch_wdata,
  input  logic [NUM_CH*2-1:0]  ch_be,
  output logic [NUM_CH-1:0]    ch_ack,
  output logic [NUM_CH-1:0]    ch_ovf,
  output logic [63:0]          rdata,
  input  logic                 ioctl_download,
  input  logic [AW-1:0]        ioctl_addr,
  input  logic [15:0]          ioctl_dout,
  output logic [AW-1:0]        sdram_addr,
  output logic [15:0]          sdram_din,
  output logic [1:0]           wtbt,
  output logic                 SDRAM_WR_PULSE,
  output logic                 SDRAM_RD_PULSE,
  output logic                 SDRAM_RD_TYPE,
  input  logic                 sdram_ready,
  input  logic [63:0]          sdram_dout
);

  localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t            state, state_n;
  logic [IW-1:0]     grant, grant_n, ptr, ptr_n, win, cand;
  logic              win_found;
  logic [NUM_CH-1:0] pend, pend_we, pend_burst, pend_clr, busy, accept, ack_n;
  logic              cur_we, cur_we_n, ready_q, done, load_rdata;
  logic              wr_n, rd_n, rd_type_n;

  logic [AW-1:0]     addr_a  [NUM_CH];
  logic [15:0]       wdata_a [NUM_CH];
  logic [1:0]        be_a    [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign addr_a[g]  = ch_addr[g*AW +: AW];
    assign wdata_a[g] = ch_wdata[g*16 +: 16];
    assign be_a[g]    = ch_be[g*2 +: 2];
  end

  // Winner search: lowest index, or rotating start just after the last winner
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (RR_EN) cand = IW'((int'(ptr) + k + 1) % NUM_CH);
      else       cand = IW'(k);
      if (!win_found && pend[cand]) begin
        win_found = 1'b1;
        win       = cand;
      end
    end
  end

  // FSM next state and registered-output next values
  always_comb begin
    state_n    = state;
    grant_n    = grant;
    ptr_n      = ptr;
    cur_we_n   = cur_we;
    pend_clr   = '0;
    ack_n      = '0;
    done       = 1'b0;
    load_rdata = 1'b0;
    wr_n       = 1'b0;
    rd_n       = 1'b0;
    rd_type_n  = SDRAM_RD_TYPE;
    case (state)
      ST_IDLE: begin
        if (win_found && sdram_ready && !ioctl_download) begin
          pend_clr[win] = 1'b1;
          if (ch_en[win]) begin
            grant_n   = win;
            ptr_n     = win;
            cur_we_n  = pend_we[win];
            wr_n      = pend_we[win];
            rd_n      = ~pend_we[win];
            rd_type_n = pend_burst[win] & ~pend_we[win];
            state_n   = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_n = ST_WAIT;
      ST_WAIT: begin
        // A level already high on entry is not a completion; only a fresh rise is
        if (sdram_ready && !ready_q) begin
          done         = 1'b1;
          ack_n[grant] = 1'b1;
          load_rdata   = ~cur_we;
          rd_type_n    = 1'b0;
          state_n      = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Channel in service until its completion cycle, so a request then is accepted
  always_comb begin
    busy = '0;
    if (state == ST_ISSUE || (state == ST_WAIT && !done)) busy[grant] = 1'b1;
  end

  assign accept = ch_req & ~pend & ~busy;

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state          <= ST_IDLE;
      grant          <= '0;
      ptr            <= IW'(NUM_CH - 1);
      cur_we         <= 1'b0;
      ready_q        <= 1'b0;
      pend           <= '0;
      pend_we        <= '0;
      pend_burst     <= '0;
      ch_ack         <= '0;
      ch_ovf         <= '0;
      rdata          <= '0;
      SDRAM_WR_PULSE <= 1'b0;
      SDRAM_RD_PULSE <= 1'b0;
      SDRAM_RD_TYPE  <= 1'b0;
    end else begin
      state          <= state_n;
      grant          <= grant_n;
      ptr            <= ptr_n;
      cur_we         <= cur_we_n;
      ready_q        <= sdram_ready;
      pend           <= (pend & ~pend_clr) | accept;
      pend_we        <= (pend_we & ~accept) | (ch_we & accept);
      pend_burst     <= (pend_burst & ~accept) | (ch_burst & accept);
      ch_ack         <= ack_n;
      ch_ovf         <= ch_req & (pend | busy);
      SDRAM_WR_PULSE <= wr_n;
      SDRAM_RD_PULSE <= rd_n;
      SDRAM_RD_TYPE  <= rd_type_n;
      if (load_rdata) rdata <= sdram_dout;
    end
  end

  // Controller-side mux; download traffic takes the bus unconditionally
  always_comb begin
    sdram_addr = '0;
    sdram_din  = '0;
    wtbt       = 2'b11;
    if (ioctl_download) begin
      sdram_addr = ioctl_addr;
      sdram_din  = ioctl_dout;
    end else if (state != ST_IDLE) begin
      sdram_addr = addr_a[grant];
      if (cur_we) begin
        sdram_din = wdata_a[grant];
        wtbt      = be_a[grant];
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: fixed-priority instance plus a round-robin instance,
// each with a simple controller model that drops ready for five cycles per access.
module tb_sdram_arbiter;

  localparam int AW = 25;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic          RESET;
  logic [3:0]    ch_req, rr_req, ch_en, ch_we, ch_burst;
  logic [4*AW-1:0] ch_addr;
  logic [63:0]   ch_wdata;
  logic [7:0]    ch_be;
  logic          ioctl_download;
  logic [AW-1:0] ioctl_addr;
  logic [15:0]   ioctl_dout;
  logic [63:0]   sdram_dout;

  logic [3:0]    ch_ack, ch_ovf, rr_ack, rr_ovf;
  logic [63:0]   rdata, rr_rdata;
  logic [AW-1:0] sdram_addr, rr_addr;
  logic [15:0]   sdram_din, rr_din;
  logic [1:0]    wtbt, rr_wtbt;
  logic          wr_p, rd_p, rd_t, rr_wr_p, rr_rd_p, rr_rd_t;
  logic          sdram_ready = 1'b1, rr_ready = 1'b1;
  int            rdy_cnt = 0, rr_cnt = 0;

  int errors = 0;
  int checks = 0;

  sdram_arbiter #(.NUM_CH(4), .AW(AW), .RR_EN(1'b0)) dut (
    .clk_sys(clk_sys), .RESET(RESET), .ch_req(ch_req), .ch_en(ch_en), .ch_we(ch_we),
    .ch_burst(ch_burst), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_be(ch_be),
    .ch_ack(ch_ack), .ch_ovf(ch_ovf), .rdata(rdata), .ioctl_download(ioctl_download),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .sdram_addr(sdram_addr),
    .sdram_din(sdram_din), .wtbt(wtbt), .SDRAM_WR_PULSE(wr_p), .SDRAM_RD_PULSE(rd_p),
    .SDRAM_RD_TYPE(rd_t), .sdram_ready(sdram_ready), .sdram_dout(sdram_dout)
  );

  sdram_arbiter #(.NUM_CH(4), .AW(AW), .RR_EN(1'b1)) dut_rr (
    .clk_sys(clk_sys), .RESET(RESET), .ch_req(rr_req), .ch_en(ch_en), .ch_we(ch_we),
    .ch_burst(ch_burst), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_be(ch_be),
    .ch_ack(rr_ack), .ch_ovf(rr_ovf), .rdata(rr_rdata), .ioctl_download(ioctl_download),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .sdram_addr(rr_addr),
    .sdram_din(rr_din), .wtbt(rr_wtbt), .SDRAM_WR_PULSE(rr_wr_p), .SDRAM_RD_PULSE(rr_rd_p),
    .SDRAM_RD_TYPE(rr_rd_t), .sdram_ready(rr_ready), .sdram_dout(sdram_dout)
  );

  // Controller models: ready low for five cycles after each start pulse
  always @(posedge clk_sys) begin
    if (wr_p || rd_p) begin
      sdram_ready <= 1'b0;
      rdy_cnt     <= 5;
    end else if (rdy_cnt != 0) begin
      rdy_cnt <= rdy_cnt - 1;
      if (rdy_cnt == 1) sdram_ready <= 1'b1;
    end
  end

  always @(posedge clk_sys) begin
    if (rr_wr_p || rr_rd_p) begin
      rr_ready <= 1'b0;
      rr_cnt   <= 5;
    end else if (rr_cnt != 0) begin
      rr_cnt <= rr_cnt - 1;
      if (rr_cnt == 1) rr_ready <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_ack(input int limit, output int lat);
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (ch_ack != 4'b0000) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic wait_pulse(input int limit, output int lat);
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (wr_p || rd_p) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    ch_req = '0; rr_req = '0; ch_en = 4'hF; ch_we = '0; ch_burst = '0;
    ch_addr = {25'h0004000, 25'h0003000, 25'h0002000, 25'h0001000};
    ch_wdata = '0; ch_be = 8'hFF;
    ioctl_download = 1'b0; ioctl_addr = '0; ioctl_dout = '0; sdram_dout = '0;
    tick(); tick();
    RESET = 1'b0;
    checks++;
    if ({ch_ack, ch_ovf, wr_p, rd_p, rd_t} !== 11'd0)
      begin errors++; $display("FAIL reset_ctrl got=%b want=0", {ch_ack, ch_ovf, wr_p, rd_p, rd_t}); end
    checks++;
    if (rdata !== 64'd0 || sdram_addr !== '0 || sdram_din !== 16'd0)
      begin errors++; $display("FAIL reset_data rdata=%h addr=%h din=%h want 0", rdata, sdram_addr, sdram_din); end
    checks++;
    if (wtbt !== 2'b11) begin errors++; $display("FAIL reset_wtbt got=%b want=11", wtbt); end
  endtask

  task automatic test_fixed_priority();
    int lat;
    sdram_dout = 64'h1111_2222_3333_4444;
    ch_req = 4'b1010; tick(); ch_req = '0; tick();
    checks++;
    if (rd_p !== 1'b1 || wr_p !== 1'b0 || sdram_addr !== 25'h0002000)
      begin errors++; $display("FAIL fp_first_issue rd=%b wr=%b addr=%h want 1 0 0002000", rd_p, wr_p, sdram_addr); end
    wait_ack(20, lat);
    checks++;
    if (lat !== 7 || ch_ack !== 4'b0010)
      begin errors++; $display("FAIL fp_first_ack lat=%0d ack=%b want 7 0010", lat, ch_ack); end
    checks++;
    if (rdata !== 64'h1111_2222_3333_4444) begin errors++; $display("FAIL fp_first_rdata got=%h", rdata); end
    sdram_dout = 64'h5555_6666_7777_8888;
    wait_pulse(10, lat);
    checks++;
    if (lat !== 1 || sdram_addr !== 25'h0004000)
      begin errors++; $display("FAIL fp_second_issue lat=%0d addr=%h want 1 0004000", lat, sdram_addr); end
    wait_ack(20, lat);
    checks++;
    if (lat !== 7 || ch_ack !== 4'b1000 || rdata !== 64'h5555_6666_7777_8888)
      begin errors++; $display("FAIL fp_second_ack lat=%0d ack=%b rdata=%h", lat, ch_ack, rdata); end
  endtask

  task automatic test_burst_and_write();
    int lat;
    ch_burst = 4'b0100; ch_we = '0; sdram_dout = 64'h0123_4567_89AB_CDEF;
    ch_req = 4'b0100; tick(); ch_req = '0; tick();
    checks++;
    if (rd_p !== 1'b1 || rd_t !== 1'b1) begin errors++; $display("FAIL burst_issue rd=%b type=%b want 1 1", rd_p, rd_t); end
    wait_ack(20, lat);
    checks++;
    if (ch_ack !== 4'b0100 || rdata !== 64'h0123_4567_89AB_CDEF)
      begin errors++; $display("FAIL burst_ack ack=%b rdata=%h", ch_ack, rdata); end
    ch_we = 4'b0100; ch_be[5:4] = 2'b01; ch_wdata[47:32] = 16'hBEEF; sdram_dout = '1;
    ch_req = 4'b0100; tick(); ch_req = '0; tick();
    checks++;
    if (wr_p !== 1'b1 || rd_p !== 1'b0 || rd_t !== 1'b0)
      begin errors++; $display("FAIL write_pulse wr=%b rd=%b type=%b want 1 0 0", wr_p, rd_p, rd_t); end
    checks++;
    if (wtbt !== 2'b01 || sdram_din !== 16'hBEEF || sdram_addr !== 25'h0003000)
      begin errors++; $display("FAIL write_mux wtbt=%b din=%h addr=%h", wtbt, sdram_din, sdram_addr); end
    wait_ack(20, lat);
    checks++;
    if (ch_ack !== 4'b0100 || rdata !== 64'h0123_4567_89AB_CDEF)
      begin errors++; $display("FAIL write_ack ack=%b rdata=%h", ch_ack, rdata); end
    ch_we = '0; ch_burst = '0; ch_be = 8'hFF;
  endtask

  task automatic test_overrun();
    int ovf_n = 0, ovf_at = -1, pulses = 0, acks = 0, other = 0;
    ch_req = 4'b0001;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (ch_ovf[0]) begin ovf_n++; ovf_at = k; end
      if (wr_p || rd_p) pulses++;
      if (ch_ack[0]) acks++;
      if (ch_ack[3:1] != 3'b000 || ch_ovf[3:1] != 3'b000) other++;
      ch_req = (k == 4) ? 4'b0001 : 4'b0000;
    end
    checks++;
    if (ovf_n !== 1 || ovf_at !== 5) begin errors++; $display("FAIL ovf_pulse count=%0d at=%0d want 1 5", ovf_n, ovf_at); end
    checks++;
    if (pulses !== 1 || acks !== 1 || other !== 0)
      begin errors++; $display("FAIL ovf_single pulses=%0d acks=%0d other=%0d want 1 1 0", pulses, acks, other); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0, second_at = -1, ovf_n = 0, acks = 0;
    ch_req = 4'b0001;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (wr_p || rd_p) begin pulses++; if (pulses == 2) second_at = k; end
      if (ch_ovf != 4'b0000) ovf_n++;
      if (ch_ack[0]) acks++;
      ch_req = (k == 8) ? 4'b0001 : 4'b0000;
    end
    checks++;
    if (pulses !== 2 || second_at !== 10 || ovf_n !== 0 || acks !== 2)
      begin errors++; $display("FAIL b2b pulses=%0d second=%0d ovf=%0d acks=%0d want 2 10 0 2", pulses, second_at, ovf_n, acks); end
  endtask

  task automatic test_disabled_channel();
    int pulses = 0, first_at = -1, ack1 = 0, ack3 = 0, lat;
    logic [AW-1:0] addr_seen = '0;
    ch_en = 4'b0111;
    ch_req = 4'b1000;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (wr_p || rd_p) begin pulses++; if (pulses == 1) begin first_at = k; addr_seen = sdram_addr; end end
      if (ch_ack[1]) ack1++;
      if (ch_ack[3]) ack3++;
      ch_req = (k == 1) ? 4'b0010 : 4'b0000;
    end
    checks++;
    if (pulses !== 1 || first_at !== 3 || addr_seen !== 25'h0002000)
      begin errors++; $display("FAIL dis_issue pulses=%0d at=%0d addr=%h want 1 3 0002000", pulses, first_at, addr_seen); end
    checks++;
    if (ack1 !== 1 || ack3 !== 0) begin errors++; $display("FAIL dis_ack ack1=%0d ack3=%0d want 1 0", ack1, ack3); end
    ch_en = 4'hF;
    ch_req = 4'b1000; tick(); ch_req = '0;
    checks++;
    if (ch_ovf !== 4'b0000) begin errors++; $display("FAIL dis_pend_cleared ovf=%b want 0000", ch_ovf); end
    tick();
    checks++;
    if (rd_p !== 1'b1 || sdram_addr !== 25'h0004000)
      begin errors++; $display("FAIL dis_reenable rd=%b addr=%h want 1 0004000", rd_p, sdram_addr); end
    wait_ack(20, lat);
  endtask

  task automatic test_download();
    int pulses = 0, bad = 0, lat;
    ioctl_download = 1'b1; ioctl_addr = 25'h155AA55; ioctl_dout = 16'hC0DE;
    ch_req = 4'b0010; tick(); ch_req = '0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (wr_p || rd_p) pulses++;
      if (sdram_addr !== 25'h155AA55 || sdram_din !== 16'hC0DE || wtbt !== 2'b11) bad++;
    end
    checks++;
    if (pulses !== 0 || bad !== 0) begin errors++; $display("FAIL dl_block pulses=%0d bad_mux=%0d want 0 0", pulses, bad); end
    ioctl_download = 1'b0;
    wait_pulse(10, lat);
    checks++;
    if (lat !== 1 || rd_p !== 1'b1 || sdram_addr !== 25'h0002000)
      begin errors++; $display("FAIL dl_resume lat=%0d rd=%b addr=%h want 1 1 0002000", lat, rd_p, sdram_addr); end
    wait_ack(20, lat);
    checks++;
    if (ch_ack !== 4'b0010) begin errors++; $display("FAIL dl_ack ack=%b want 0010", ch_ack); end
  endtask

  task automatic test_round_robin();
    int order [8];
    int n = 0;
    int exp_ch;
    rr_req = 4'b1111;
    for (int k = 0; k < 300 && n < 8; k++) begin
      tick();
      if (rr_rd_p) begin
        order[n] = int'(rr_addr >> 12) - 1;
        n++;
      end
    end
    rr_req = '0;
    checks++;
    if (n !== 8) begin errors++; $display("FAIL rr_timeout grants=%0d want 8", n); end
    for (int i = 0; i < n; i++) begin
      exp_ch = i % 4;
      checks++;
      if (order[i] !== exp_ch) begin errors++; $display("FAIL rr_order idx=%0d got=%0d want=%0d", i, order[i], exp_ch); end
    end
  endtask

  task automatic test_reset_mid_access();
    int pulses = 0, acks = 0;
    ch_req = 4'b0001; tick(); ch_req = '0; tick();
    checks++;
    if (rd_p !== 1'b1) begin errors++; $display("FAIL rst_mid_issue rd=%b want 1", rd_p); end
    tick(); tick();
    RESET = 1'b1; tick(); RESET = 1'b0;
    checks++;
    if ({ch_ack, ch_ovf, wr_p, rd_p, rd_t} !== 11'd0 || rdata !== 64'd0 || sdram_addr !== '0 || wtbt !== 2'b11)
      begin errors++; $display("FAIL rst_mid_outputs ctrl=%b rdata=%h addr=%h wtbt=%b", {ch_ack, ch_ovf, wr_p, rd_p, rd_t}, rdata, sdram_addr, wtbt); end
    for (int k = 0; k < 15; k++) begin
      tick();
      if (wr_p || rd_p) pulses++;
      if (ch_ack != 4'b0000) acks++;
    end
    checks++;
    if (pulses !== 0 || acks !== 0) begin errors++; $display("FAIL rst_mid_no_ack pulses=%0d acks=%0d want 0 0", pulses, acks); end
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_burst_and_write();
    test_overrun();
    test_back_to_back();
    test_disabled_channel();
    test_download();
    test_round_robin();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Parametrised N-channel SDRAM request arbiter, successor to the fixed four-source mux: 68k read, CD write, C ROM burst, S ROM.
- Sits between requesters (68k/DMA, LSPC sprite and fix fetchers, CD transfer unit) and the single-port SDRAM controller.
- Latches one-cycle request strobes into pending flags and grants with fixed or round-robin priority.
- Issues one pulse-started access at a time, returns 64-bit read data per channel, flags overruns, and passes HPS download through.

Parameters:
- NUM_CH, 4, number of requester channels (2..8); index 0 is highest fixed priority.
- AW, 25, SDRAM byte address width.
- RR_EN, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk_sys  in  1  system clock
- RESET  in  1  synchronous reset, active-high
- ch_req  in  NUM_CH  one-cycle request strobe per channel
- ch_en  in  NUM_CH  channel enable, sampled at grant
- ch_we  in  NUM_CH  1 = write, 0 = read; sampled with ch_req
- ch_burst  in  NUM_CH  1 = 64-bit burst read; ignored for writes
- ch_addr  in  NUM_CH*AW  byte address per channel; held until ch_ack
- ch_wdata  in  NUM_CH*16  write data; held until ch_ack
- ch_be  in  NUM_CH*2  byte enables {upper, lower}
- ch_ack  out  NUM_CH  one-cycle completion pulse
- ch_ovf  out  NUM_CH  one-cycle overrun pulse
- rdata  out  64  last read data, valid with ch_ack of a read
- ioctl_download  in  1  HPS load active
- ioctl_addr  in  AW  download address
- ioctl_dout  in  16  download data
- sdram_addr  out  AW  address to controller
- sdram_din  out  16  write data to controller
- wtbt  out  2  byte-write enables to controller
- SDRAM_WR_PULSE  out  1  one-cycle write start
- SDRAM_RD_PULSE  out  1  one-cycle read start
- SDRAM_RD_TYPE  out  1  1 = burst, 0 = single
- sdram_ready  in  1  controller idle/done level
- sdram_dout  in  64  controller read data

Behaviour:
- Reset values: all outputs 0, except wtbt = 2'b11.
- Reset clears pending, grant, state and RR pointer (pointer = NUM_CH-1, so channel 0 is searched first).
- Reset mid-access: the in-flight completion is ignored and no ack is issued.
- Pending: ch_req[i] sets pend[i] at the next edge, latching ch_we[i] and ch_burst[i].
- Overrun: ch_req[i] while pend[i] is set or channel i is in service gives ch_ovf[i] one cycle later; the request is dropped.
- FSM states:
  - IDLE -> ISSUE when pend != 0, sdram_ready = 1 and ioctl_download = 0.
  - Winner: lowest index (RR_EN = 0), or first set bit searching from ptr+1 with wrap-around (RR_EN = 1).
  - Winner's pend bit clears; grant index is registered; RR pointer updates to the winner.
  - Winner with ch_en = 0: pend clears, no access, no ack, no pointer update, stay IDLE.
  - ISSUE: SDRAM_WR_PULSE or SDRAM_RD_PULSE high for exactly one cycle; SDRAM_RD_TYPE = burst & ~we. Go to WAIT.
  - WAIT: completion on rising edge of sdram_ready (registered previous vs current); an initial high level is never taken as completion.
  - On completion: read loads rdata <= sdram_dout; write leaves rdata unchanged. ch_ack[grant] pulses, then IDLE.
- Latency: ch_req in cycle 0 -> pulse in cycle 2 if idle and ready. ch_ack is 1 cycle after the ready rising edge.
- Muxing while granted (ISSUE/WAIT):
  - sdram_addr = ch_addr[grant].
  - Write: sdram_din = ch_wdata[grant], wtbt = ch_be[grant]. Read: wtbt = 2'b11, sdram_din = 0.
  - Otherwise sdram_addr = 0.
- ioctl_download = 1 overrides the muxing: sdram_addr = ioctl_addr, sdram_din = ioctl_dout, wtbt = 2'b11.
- Download also blocks new grants; the in-flight access completes normally and pend bits are retained and served after download ends.
- Simultaneous events:
  - Request arriving in the same cycle as that channel's completion is accepted, with no overrun.
  - Requests on several channels in one cycle all set pend.

Test Plan:
- RR_EN=0, NUM_CH=4, pulse ch_req=4'b1010 in the same cycle, ready model 5-cycle busy -> channel 1 served first, then 3; each ch_ack follows its ready rising edge; RD_PULSE in cycle 2.
- RR_EN=1, hold all four requesting repeatedly -> grant order 0,1,2,3,0,...; no channel waits more than 3 accesses.
- Burst read on ch 2, sdram_dout=64'h0123_4567_89AB_CDEF -> RD_TYPE=1; rdata equals that value with ch_ack[2]. A following write, ch_be=2'b01 and data 16'hBEEF, gives wtbt=2'b01, sdram_din=16'hBEEF and leaves rdata unchanged.
- Second ch_req[0] during its WAIT -> ch_ovf[0] pulses once; exactly one SDRAM pulse and one ch_ack[0].
- ch_en[3]=0 with pend[3] set -> no pulse, no ack, pend[3] cleared; ch_en=0 on a pending channel never stalls the others.
- ioctl_download=1 with ch 1 pending -> no pulse, sdram_addr=ioctl_addr; on deassert ch 1 is issued. RESET asserted in WAIT -> all outputs 0 next cycle, no ack after ready rises.
